bin2bcd_display: RTL

Iterative binary-to-BCD converter and 7-segment driver that consumes the 27-bit calculator result and drives the board's eight active-low 7-segment digits. A `start` pulse launches a shift-add-3 (double-dabble) conversion of the captured value. On completion the block registers the packed BCD word and the segment patterns, and raises `done` for one cycle. Values above the 8-digit display range are flagged as overflow and shown as dashes.

---
 rtl/bin2bcd_display_if.sv | 31 +++
 rtl/bin2bcd_display.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_display_if.sv
// Bus between the calculator stage and the BCD / 7-segment display block.
//   value  : unsigned binary result to convert (WIDTH bits)
//   start  : conversion request
//   busy   : conversion in progress
//   done   : one-cycle pulse when bcd/hex/ovf are updated
//   ovf    : last converted value exceeded the 8-digit display range
//   bcd    : packed BCD result, digit 0 in bits [3:0]
//   hex    : active-low segments, digit n in [7n+6:7n], bit 0 = a .. bit 6 = g
// Modports: master drives value/start, slave (the converter) drives the rest.
interface bin2bcd_display_if #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
);
  logic [WIDTH-1:0]    value;
  logic                start;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [DIGITS*4-1:0] bcd;
  logic [DIGITS*7-1:0] hex;

  modport master (
    output value, start,
    input  busy, done, ovf, bcd, hex
  );

  modport slave (
    input  value, start,
    output busy, done, ovf, bcd, hex
  );
endinterface

// File: rtl/bin2bcd_display.sv
// Iterative binary-to-BCD converter (shift-add-3) with 7-segment driver.
// A start request in IDLE latches the value; WIDTH shift iterations follow,
// then one FINISH cycle registers bcd/hex/ovf and pulses done.
// Values above 99_999_999 set ovf, clear bcd and show dashes on every digit.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bin2bcd_display_if.slave (value, start in; busy, done, ovf, bcd, hex out)
// Optional build macro:
//   BIN2BCD_BLANK_EN : leading-zero blanking of the segment outputs
//                      (digit 0 always shown, dashes never blanked, bcd unaffected).
module bin2bcd_display #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  bin2bcd_display_if.slave        bus
);

  // One spare digit of scratch keeps every 27-bit conversion exact.
  localparam int SCR_W = (DIGITS + 1) * 4;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [WIDTH-1:0]    value_r;
  logic [WIDTH-1:0]    shift_r;
  logic [SCR_W-1:0]    scratch_r;
  logic [SCR_W-1:0]    adj_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r;
  logic                done_r;
  logic                ovf_r;
  logic [DIGITS*4-1:0] bcd_r;
  logic [DIGITS*7-1:0] hex_r;
  logic [DIGITS*7-1:0] hex_dec_s;
  logic                over_s;

  // Active-low 7-segment pattern for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [SCR_W-1:0] add3_all(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  assign adj_s  = add3_all(scratch_r);
  // Overflow is judged on the latched binary value, not on the scratch.
  assign over_s = (32'(value_r) > 32'd99_999_999);

`ifdef BIN2BCD_BLANK_EN
  logic lead_s;

  // Segment decode with leading zeros blanked; digit 0 is always shown.
  always_comb begin
    lead_s    = 1'b1;
    hex_dec_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (lead_s && (i != 0) && (scratch_r[4*i +: 4] == 4'd0)) begin
        hex_dec_s[7*i +: 7] = 7'h7F;
      end else begin
        lead_s              = 1'b0;
        hex_dec_s[7*i +: 7] = seg7(scratch_r[4*i +: 4]);
      end
    end
  end
`else
  // Segment decode of every digit, leading zeros included.
  always_comb begin
    hex_dec_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hex_dec_s[7*i +: 7] = seg7(scratch_r[4*i +: 4]);
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_next_s = CONV;
        else           state_next_s = IDLE;
      end
      CONV: begin
        if (cnt_r == CNT_LAST) state_next_s = FINISH;
        else                   state_next_s = CONV;
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r   <= '0;
      shift_r   <= '0;
      scratch_r <= '0;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      bcd_r     <= '0;
      hex_r     <= {DIGITS{7'h7F}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            value_r   <= bus.value;
            shift_r   <= bus.value;
            scratch_r <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b1;
          end
        end
        CONV: begin
          // The bit shifted out of the top of the scratch is always zero.
          {scratch_r, shift_r} <= {adj_s, shift_r} << 1;
          cnt_r                <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        FINISH: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (over_s) begin
            ovf_r <= 1'b1;
            bcd_r <= '0;
            hex_r <= {DIGITS{7'h3F}};
          end else begin
            ovf_r <= 1'b0;
            bcd_r <= scratch_r[DIGITS*4-1:0];
            hex_r <= hex_dec_s;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.ovf  = ovf_r;
  assign bus.bcd  = bcd_r;
  assign bus.hex  = hex_r;

endmodule
